// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional illegal-opcode trap state enabled by defining MIPS_ILLEGAL_OP_TRAP_EN.
module mips_mc_control #(
    parameter int OPCODE_W = 6,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                illegal_op,
    output logic [STATE_W-1:0]  state
);

    localparam logic [STATE_W-1:0] S_RESET    = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEM_ADDR = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEM_RD   = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEM_WB   = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_MEM_WR   = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_R_EXEC   = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_R_WB     = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_JUMP     = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_I_EXEC   = STATE_W'(11);
    localparam logic [STATE_W-1:0] S_I_WB     = STATE_W'(12);
`ifdef MIPS_ILLEGAL_OP_TRAP_EN
    localparam logic [STATE_W-1:0] S_TRAP     = STATE_W'(13);
`endif

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    ctrl_t              ctrl;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEM_ADDR;
                end else if (opcode == OP_R) begin
                    state_d = S_R_EXEC;
                end else if (opcode == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (opcode == OP_J) begin
                    state_d = S_JUMP;
                end else if (opcode == OP_ADDI) begin
                    state_d = S_I_EXEC;
                end else begin
`ifdef MIPS_ILLEGAL_OP_TRAP_EN
                    state_d = S_TRAP;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            // IR still holds the opcode decoded last cycle, so it selects load vs store here.
            S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EXEC:   state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_I_EXEC:   state_d = S_I_WB;
            S_I_WB:     state_d = S_FETCH;
`ifdef MIPS_ILLEGAL_OP_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // NOTE: clearing the whole bundle before the case keeps every output assigned on every path, so no latches.
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = 2'b11;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = 2'b10;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = 2'b01;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 2'b01;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = 2'b10;
            end
            S_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
            end
            S_I_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign state         = state_q;

`ifdef MIPS_ILLEGAL_OP_TRAP_EN
    assign illegal_op = (state_q == S_TRAP);
`else
    assign illegal_op = 1'b0;
`endif

    a_mem_excl: assert property (@(posedge clk) !(mem_read && mem_write));
    a_pc_excl:  assert property (@(posedge clk) !(pc_write && pc_write_cond));

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control: vector table, directed reset/trap sequences,
// and randomized instruction streams checked against a path-based reference model.
module tb_mips_mc_control;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    mips_mc_control #(.OPCODE_W(6), .STATE_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle order: pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
    // mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } outs_t;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [47:0] seq;
        logic [11:0] rdy;
        int          cycles;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic outs_t actual_outs();
        outs_t o;
        o = '{pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
              reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};
        return o;
    endfunction

    // Reference control table, written straight from the state descriptions.
    function automatic outs_t exp_outs(input logic [3:0] s, input logic rdy);
        outs_t o;
        o = '0;
        case (s)
            4'd1:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
            4'd2:  o.alu_src_b = 2'b11;
            4'd3:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            4'd4:  begin o.mem_read = 1; o.iord = 1; end
            4'd5:  begin o.reg_write = 1; o.mem_to_reg = 1; end
            4'd6:  begin o.mem_write = 1; o.iord = 1; end
            4'd7:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            4'd8:  begin o.reg_write = 1; o.reg_dst = 1; end
            4'd9:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_source = 2'b01; end
            4'd10: begin o.pc_write = 1; o.pc_source = 2'b10; end
            4'd11: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            4'd12: o.reg_write = 1;
`ifdef MIPS_ILLEGAL_OP_TRAP_EN
            4'd13: o.illegal_op = 1;
`endif
            default: o = '0;
        endcase
        return o;
    endfunction

    // Zero-wait state path of one instruction, one nibble per step, MSB first, 0 terminates.
    function automatic logic [47:0] path_of(input logic [5:0] op);
        case (op)
            OP_R:    return 48'h1278_0000_0000;
            OP_LW:   return 48'h1234_5000_0000;
            OP_SW:   return 48'h1236_0000_0000;
            OP_BEQ:  return 48'h1290_0000_0000;
            OP_J:    return 48'h12A0_0000_0000;
            OP_ADDI: return 48'h12BC_0000_0000;
`ifdef MIPS_ILLEGAL_OP_TRAP_EN
            default: return 48'h12D0_0000_0000;
`else
            default: return 48'h1200_0000_0000;
`endif
        endcase
    endfunction

    function automatic logic [3:0] nib(input logic [47:0] p, input int i);
        return p[47-4*i -: 4];
    endfunction

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 6))
            0: return OP_R;
            1: return OP_LW;
            2: return OP_SW;
            3: return OP_BEQ;
            4: return OP_J;
            5: return OP_ADDI;
`ifdef MIPS_ILLEGAL_OP_TRAP_EN
            default: return OP_LW;
`else
            default: return 6'($urandom);
`endif
        endcase
    endfunction

    // Called at a negedge: drive inputs, check state and outputs, advance to the next negedge.
    task automatic step_check(input logic [5:0] op, input logic rdy, input logic [3:0] es,
                              input string name);
        opcode    = op;
        mem_ready = rdy;
        #1;
        check({name, " state"}, 32'(state), 32'(es));
        check({name, " outs"}, 32'(actual_outs()), 32'(exp_outs(es, rdy)));
        @(negedge clk);
    endtask

    task automatic add_vec(input string n, input logic [5:0] op, input logic [47:0] seq,
                           input logic [11:0] rdy, input int cycles);
        vec_t v;
        v.name = n; v.op = op; v.seq = seq; v.rdy = rdy; v.cycles = cycles;
        vecs.push_back(v);
    endtask

    initial begin
        int          idx;
        int          obs;
        bit          left;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  es;
        logic [47:0] path;

        // Sequences include the trailing FETCH, held with mem_ready=0.
        add_vec("r_type",      OP_R,    48'h1278_1000_0000, 12'b1111_0000_0000, 4);
        add_vec("lw_stall3",   OP_LW,   48'h1234_4445_1000, 12'b1110_0011_0000, 8);
        add_vec("sw",          OP_SW,   48'h1236_1000_0000, 12'b1111_0000_0000, 4);
        add_vec("addi",        OP_ADDI, 48'h12BC_1000_0000, 12'b1111_0000_0000, 4);
        add_vec("beq",         OP_BEQ,  48'h1291_0000_0000, 12'b1110_0000_0000, 3);
        add_vec("j",           OP_J,    48'h12A1_0000_0000, 12'b1110_0000_0000, 3);
        add_vec("fetch_stall", OP_R,    48'h1112_7810_0000, 12'b0011_1100_0000, 6);
        add_vec("sw_stall1",   OP_SW,   48'h1236_6100_0000, 12'b1110_1000_0000, 5);
`ifndef MIPS_ILLEGAL_OP_TRAP_EN
        add_vec("illegal_nop", OP_BAD,  48'h1210_0000_0000, 12'b1100_0000_0000, 2);
`endif

        rst = 1'b1;
        opcode = 6'd0;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        step_check(OP_R, 1'b1, 4'd0, "reset_hold");
        rst = 1'b0;
        step_check(OP_R, 1'b0, 4'd0, "reset_release");

        foreach (vecs[k]) begin
            left = 0;
            obs  = -1;
            for (int i = 0; i < 12; i++) begin
                es = nib(vecs[k].seq, i);
                if (es == 4'd0) break;
                if (state != 4'd1) left = 1;
                else if (left && obs < 0) obs = i;
                step_check(vecs[k].op, vecs[k].rdy[11-i], es, vecs[k].name);
            end
            check({vecs[k].name, " cycles"}, 32'(obs), 32'(vecs[k].cycles));
        end

        // Reset asserted for two cycles while MEM_RD is stalled.
        step_check(OP_LW, 1'b1, 4'd1, "rst_mid");
        step_check(OP_LW, 1'b1, 4'd2, "rst_mid");
        step_check(OP_LW, 1'b1, 4'd3, "rst_mid");
        step_check(OP_LW, 1'b0, 4'd4, "rst_mid");
        rst = 1'b1;
        step_check(OP_LW, 1'b0, 4'd4, "rst_mid");
        step_check(OP_LW, 1'b1, 4'd0, "rst_mid");
        rst = 1'b0;
        step_check(OP_LW, 1'b1, 4'd0, "rst_mid");
        step_check(OP_LW, 1'b0, 4'd1, "rst_mid_fetch");

        // Random instruction stream against the path model.
        idx = 0;
        op  = OP_R;
        for (int c = 0; c < 2000; c++) begin
            if (idx == 0) op = pick_op();
            rdy  = ($urandom_range(0, 3) != 0);
            path = path_of(op);
            es   = nib(path, idx);
            step_check(op, rdy, es, "rand");
            if (!((es == 4'd1 || es == 4'd4 || es == 4'd6) && !rdy)) begin
                idx++;
                if (idx > 11 || nib(path, idx) == 4'd0) idx = 0;
            end
        end

`ifdef MIPS_ILLEGAL_OP_TRAP_EN
        // Finish the current instruction with mem_ready=1 until back in FETCH.
        for (int c = 0; c < 20 && idx != 0; c++) begin
            path = path_of(op);
            step_check(op, 1'b1, nib(path, idx), "drain");
            idx++;
            if (idx > 11 || nib(path, idx) == 4'd0) idx = 0;
        end
        step_check(OP_BAD, 1'b1, 4'd1, "trap");
        step_check(OP_BAD, 1'b1, 4'd2, "trap");
        for (int c = 0; c < 5; c++) step_check(OP_BAD, 1'($urandom), 4'd13, "trap_hold");
        rst = 1'b1;
        step_check(OP_BAD, 1'b1, 4'd13, "trap_hold");
        step_check(OP_BAD, 1'b1, 4'd0, "trap_rst");
        rst = 1'b0;
        step_check(OP_R, 1'b0, 4'd0, "trap_rst");
        step_check(OP_R, 1'b0, 4'd1, "trap_fetch");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
